// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sharing arbiter: opcodes, FSM states, datapath width.
package fpu_pkg;

  localparam int FP_W = 32;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin grant, purely combinational; the pointer picks the winner
// only when both requesters are valid.
module fpu_rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic       o_gnt_vld,
  output logic       o_gnt_id
);

  always_comb begin
    o_gnt_vld = |i_valid;
    if (&i_valid) o_gnt_id = i_ptr;
    else          o_gnt_id = i_valid[1];
  end

endmodule

// File: rtl/fpu_arbiter_seq.sv
// Shares one multi-cycle FPU between two requesters, one op in flight at a time.
// Accept -> response valid after LAT(op) cycles; response held until rsp_ready.
module fpu_arbiter_seq
  import fpu_pkg::*;
#(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_DIV = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_op,
  input  logic [2*FP_W-1:0] req_a,
  input  logic [2*FP_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [FP_W-1:0]   rsp_result,
  output logic              rsp_of,
  output logic              rsp_uf,
  output logic [1:0]        fpu_op,
  output logic [FP_W-1:0]   fpu_a,
  output logic [FP_W-1:0]   fpu_b,
  input  logic [FP_W-1:0]   fpu_result,
  input  logic              fpu_of,
  input  logic              fpu_uf,
  output logic              busy
);

  localparam int LAT_MAX = max3(LAT_ADD, LAT_MUL, LAT_DIV);
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  generate
    if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1) begin : g_bad_lat
      $error("fpu_arbiter_seq: every LAT_* must be >= 1");
    end
  endgenerate

  state_t            r_state;
  state_t            w_nxt_state;
  logic              r_rr_ptr;
  logic              r_id;
  logic [1:0]        r_op;
  logic [FP_W-1:0]   r_a;
  logic [FP_W-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic [FP_W-1:0]   r_result;
  logic              r_of;
  logic              r_uf;

  logic              w_gnt_vld;
  logic              w_gnt_id;
  logic              w_acc;
  logic [1:0]        w_sel_op;
  logic [FP_W-1:0]   w_sel_a;
  logic [FP_W-1:0]   w_sel_b;

  // Counter is loaded with LAT-1 so the EXEC phase spans exactly LAT cycles.
  function automatic logic [CW-1:0] f_lat_m1(input logic [1:0] op);
    case (op)
      OP_MUL:  return CW'(LAT_MUL - 1);
      OP_DIV:  return CW'(LAT_DIV - 1);
      default: return CW'(LAT_ADD - 1);
    endcase
  endfunction

  fpu_rr_arb2 u_arb (
    .i_valid   (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_id  (w_gnt_id)
  );

  assign w_sel_op = w_gnt_id ? req_op[3:2]         : req_op[1:0];
  assign w_sel_a  = w_gnt_id ? req_a[2*FP_W-1:FP_W] : req_a[FP_W-1:0];
  assign w_sel_b  = w_gnt_id ? req_b[2*FP_W-1:FP_W] : req_b[FP_W-1:0];

  always_comb begin
    w_nxt_state = r_state;
    req_ready   = 2'b00;
    w_acc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          req_ready[w_gnt_id] = 1'b1;
          w_acc               = 1'b1;
          w_nxt_state         = ST_EXEC;
        end
      end
      ST_EXEC: if (r_cnt == '0) w_nxt_state = ST_RESP;
      ST_RESP: if (rsp_ready)   w_nxt_state = ST_IDLE;
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
      r_id     <= 1'b0;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_of     <= 1'b0;
      r_uf     <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      if (w_acc) begin
        r_id     <= w_gnt_id;
        r_op     <= w_sel_op;
        r_a      <= w_sel_a;
        r_b      <= w_sel_b;
        r_cnt    <= f_lat_m1(w_sel_op);
        r_rr_ptr <= ~w_gnt_id;
      end
      if (r_state == ST_EXEC) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_result <= fpu_result;
          r_of     <= fpu_of;
          r_uf     <= fpu_uf;
        end
      end
    end
  end

  assign fpu_op     = r_op;
  assign fpu_a      = r_a;
  assign fpu_b      = r_b;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_of     = r_of;
  assign rsp_uf     = r_uf;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fpu_arbiter_seq.sv
// Directed bench for fpu_arbiter_seq with a small table-driven FPU model.
module tb_fpu_arbiter_seq;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_of;
  logic        rsp_uf;
  logic [1:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        fpu_of;
  logic        fpu_uf;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_arbiter_seq #(.LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_of     (rsp_of),
    .rsp_uf     (rsp_uf),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .fpu_of     (fpu_of),
    .fpu_uf     (fpu_uf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known IEEE vectors return real answers; anything else returns a+b+op so results are traceable.
  always_comb begin
    fpu_result = fpu_a + fpu_b + {30'd0, fpu_op};
    fpu_of     = 1'b0;
    fpu_uf     = 1'b0;
    if (fpu_op == 2'd0 && fpu_a == 32'h3F800000 && fpu_b == 32'h40000000) begin
      fpu_result = 32'h40400000;
    end else if (fpu_op == 2'd2 && fpu_a == 32'h7F000000 && fpu_b == 32'h7F000000) begin
      fpu_result = 32'h7F800000;
      fpu_of     = 1'b1;
    end else if (fpu_op == 2'd3 && fpu_a == 32'h00800000 && fpu_b == 32'h7F000000) begin
      fpu_result = 32'h00000000;
      fpu_uf     = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (fpu_op !== 2'd0 || fpu_a !== 32'd0 || fpu_b !== 32'd0) begin n_fail++; $display("FAIL reset_fpu: got op=%h a=%h b=%h want 0", fpu_op, fpu_a, fpu_b); end
    n_checks++; if (rsp_result !== 32'd0 || rsp_of !== 1'b0 || rsp_uf !== 1'b0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got res=%h of=%b uf=%b id=%b want 0", rsp_result, rsp_of, rsp_uf, rsp_id); end
  endtask

  task automatic test_add();
    int cyc;
    int busy_low;
    rsp_ready = 1'b1;
    req_op    = 4'b0000;
    req_a     = {32'h0, 32'h3F800000};
    req_b     = {32'h0, 32'h40000000};
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_req_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    busy_low  = 0;
    cyc       = 0;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      if (busy !== 1'b1) busy_low++;
      tick();
      cyc++;
    end
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", cyc); end
    n_checks++; if (busy_low != 0 || busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %0d low cycles want 0", busy_low); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL add_id: got %b want 0", rsp_id); end
    n_checks++; if (rsp_result !== 32'h40400000) begin n_fail++; $display("FAIL add_result: got %h want 40400000", rsp_result); end
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_idle: got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int n_gnt0;
    int n_gnt1;
    logic exp_id;
    do_reset();
    rsp_ready = 1'b1;
    req_op    = 4'b1110;
    req_a     = {32'h00000100, 32'h00000010};
    req_b     = {32'h00000200, 32'h00000020};
    req_valid = 2'b11;
    n_gnt0    = 0;
    n_gnt1    = 0;
    #1;
    for (int k = 0; k < 20; k++) begin
      exp_id = ((k % 2) == 1);
      n_checks++; if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_grant op%0d: got %b want id %b", k, req_ready, exp_id); end
      tick();
      wait_rsp(cyc);
      n_checks++; if (cyc != (exp_id ? 8 : 3)) begin n_fail++; $display("FAIL rr_latency op%0d: got %0d want %0d", k, cyc, exp_id ? 8 : 3); end
      n_checks++; if (rsp_id !== exp_id) begin n_fail++; $display("FAIL rr_id op%0d: got %b want %b", k, rsp_id, exp_id); end
      n_checks++; if (rsp_result !== (exp_id ? 32'h00000303 : 32'h00000032)) begin n_fail++; $display("FAIL rr_result op%0d: got %h want %h", k, rsp_result, exp_id ? 32'h303 : 32'h32); end
      if (rsp_id === 1'b1) n_gnt1++; else n_gnt0++;
      tick();
    end
    req_valid = 2'b00;
    n_checks++; if (n_gnt0 != 10 || n_gnt1 != 10) begin n_fail++; $display("FAIL rr_fairness: got %0d/%0d want 10/10", n_gnt0, n_gnt1); end
  endtask

  task automatic test_div_hold();
    int bad;
    rsp_ready = 1'b1;
    req_op    = 4'b1100;
    req_a     = {32'h40A00000, 32'h0};
    req_b     = {32'h40000000, 32'h0};
    req_valid = 2'b10;
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL div_grant: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    req_op    = 4'b0101;
    req_a     = {32'hDEADBEEF, 32'h12345678};
    req_b     = {32'hCAFEF00D, 32'h87654321};
    bad       = 0;
    for (int i = 0; i < 8; i++) begin
      if (fpu_op !== 2'd3 || fpu_a !== 32'h40A00000 || fpu_b !== 32'h40000000) bad++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL div_hold: got %0d bad cycles want 0", bad); end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL div_latency: got rsp_valid=%b after 8 cycles want 1", rsp_valid); end
    n_checks++; if (rsp_result !== 32'h80A00003 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL div_result: got %h id=%b want 80a00003 id=1", rsp_result, rsp_id); end
    tick();
    n_checks++; if (fpu_a !== 32'h40A00000 || fpu_op !== 2'd3) begin n_fail++; $display("FAIL div_idle_hold: got a=%h op=%h want 40a00000 3", fpu_a, fpu_op); end
  endtask

  task automatic test_rsp_stall();
    int cyc;
    int bad;
    rsp_ready = 1'b0;
    req_op    = 4'b0100;
    req_a     = {32'h00000005, 32'h00001000};
    req_b     = {32'h00000006, 32'h00002000};
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b11;
    wait_rsp(cyc);
    n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL stall_latency: got %0d want 2", cyc); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h00003000 || rsp_id !== 1'b0) bad++;
      if (req_ready !== 2'b00 || busy !== 1'b1) bad++;
      tick();
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_no_grant: got %b want 00", req_ready); end
    tick();
    n_checks++; if (busy !== 1'b0 || req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_release: got busy=%b ready=%b want 0 10", busy, req_ready); end
    tick();
    n_checks++; if (busy !== 1'b1 || fpu_op !== 2'd1 || fpu_a !== 32'h00000005) begin n_fail++; $display("FAIL stall_next_accept: got busy=%b op=%h a=%h want 1 1 5", busy, fpu_op, fpu_a); end
    req_valid = 2'b00;
    wait_rsp(cyc);
    n_checks++; if (rsp_result !== 32'h0000000C || rsp_id !== 1'b1) begin n_fail++; $display("FAIL stall_next_result: got %h id=%b want c id=1", rsp_result, rsp_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    rsp_ready = 1'b1;
    req_op    = 4'b0010;
    req_a     = {32'h0, 32'h00000007};
    req_b     = {32'h0, 32'h00000009};
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got busy=%b want 1", busy); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_ctrl: got busy=%b rsp_valid=%b ready=%b want 0", busy, rsp_valid, req_ready); end
    n_checks++; if (fpu_op !== 2'd0 || fpu_a !== 32'd0 || fpu_b !== 32'd0) begin n_fail++; $display("FAIL midrst_fpu: got op=%h a=%h b=%h want 0", fpu_op, fpu_a, fpu_b); end
    n_checks++; if (rsp_result !== 32'd0 || rsp_of !== 1'b0 || rsp_uf !== 1'b0 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp: got res=%h of=%b uf=%b id=%b want 0", rsp_result, rsp_of, rsp_uf, rsp_id); end
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_rsp: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_flags();
    int cyc;
    rsp_ready = 1'b1;
    req_op    = 4'b1011;
    req_a     = {32'h7F000000, 32'h00800000};
    req_b     = {32'h7F000000, 32'h7F000000};
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = 2'b00;
    wait_rsp(cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL of_latency: got %0d want 3", cyc); end
    n_checks++; if (rsp_of !== 1'b1 || rsp_uf !== 1'b0) begin n_fail++; $display("FAIL of_flags: got of=%b uf=%b want 1 0", rsp_of, rsp_uf); end
    n_checks++; if (rsp_id !== 1'b1 || rsp_result !== 32'h7F800000) begin n_fail++; $display("FAIL of_rsp: got id=%b res=%h want 1 7f800000", rsp_id, rsp_result); end
    tick();
    req_valid = 2'b01;
    #1;
    tick();
    req_valid = 2'b00;
    wait_rsp(cyc);
    n_checks++; if (cyc != 8) begin n_fail++; $display("FAIL uf_latency: got %0d want 8", cyc); end
    n_checks++; if (rsp_of !== 1'b0 || rsp_uf !== 1'b1) begin n_fail++; $display("FAIL uf_flags: got of=%b uf=%b want 0 1", rsp_of, rsp_uf); end
    n_checks++; if (rsp_id !== 1'b0 || rsp_result !== 32'h00000000) begin n_fail++; $display("FAIL uf_rsp: got id=%b res=%h want 0 0", rsp_id, rsp_result); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_div_hold();
    test_rsp_stall();
    test_reset_mid();
    test_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
